// File: rtl/change_logger_pkg.sv
// Shared parameters and entry layout for the change_logger capture block.
// An entry is {timestamp, value}, with the value in the low bits.
package change_logger_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_TS_W   = 16;
  localparam int unsigned DEF_DEPTH  = 8;

  localparam int unsigned ENTRY_W    = DEF_TS_W + DEF_DATA_W;
  localparam int unsigned VALUE_LSB  = 0;

  // Timestamp field sits directly above the value field.
  function automatic int unsigned ts_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned ts_w);
    return data_w + ts_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head data is read straight from
// the storage registers, so nothing on the pop side reaches valid combinationally.
module sync_fifo
  import change_logger_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             pop_ok_c;
  logic             push_ok_c;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pop_ok_c  = pop & valid_q;
    push_ok_c = push & (~full_q | pop_ok_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = valid_q;
  assign full     = full_q;
  assign count    = count_q;

endmodule

// File: rtl/change_logger.sv
// Hardware $monitor: logs every change of sample_in as a {timestamp, value}
// entry into a FIFO drained over valid/ready, with a sticky drop flag.
module change_logger
  import change_logger_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TS_W   = DEF_TS_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        sample_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_value,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned EW     = entry_w(DATA_W, TS_W);
  localparam int unsigned TS_LSB = ts_lsb(DATA_W);

  logic [TS_W-1:0]   time_q, time_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              armed_q, armed_d;
  logic              ovf_q, ovf_d;
  logic              log_c;
  logic              pop_c;
  logic              drop_c;
  logic              fifo_full;
  logic [EW-1:0]     head;

  // Change detector, free-running timestamp and sticky overflow.
  always_comb begin
    time_d  = time_q;
    prev_d  = prev_q;
    armed_d = 1'b0;
    ovf_d   = ovf_q;
    pop_c   = out_valid & out_ready;
    log_c   = enable & (~armed_q | (sample_in != prev_q));
    drop_c  = log_c & fifo_full & ~pop_c;
    if (enable) begin
      time_d  = time_q + TS_W'(1);
      armed_d = 1'b1;
    end
    // A dropped entry still becomes the new baseline.
    if (log_c) begin
      prev_d = sample_in;
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (log_c),
    .push_data ({time_q, sample_in}),
    .pop       (pop_c),
    .pop_data  (head),
    .valid     (out_valid),
    .full      (fifo_full),
    .count     (count)
  );

  assign out_value = head[VALUE_LSB +: DATA_W];
  assign out_time  = head[TS_LSB +: TS_W];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_change_logger.sv
// Self-checking bench for change_logger: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_change_logger;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_value;
  logic [TS_W-1:0]   out_time;
  logic [3:0]        count;
  logic              overflow;
  logic              clear_ovf = 1'b0;

  // Narrow-timestamp instance for the wrap scenario.
  logic              rst4 = 1'b1;
  logic              en4 = 1'b0;
  logic [DATA_W-1:0] s4 = '0;
  logic              rdy4 = 1'b0;
  logic              clr4 = 1'b0;
  logic              valid4;
  logic [DATA_W-1:0] value4;
  logic [3:0]        time4;
  logic [3:0]        count4;
  logic              ovf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_logger #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_time(out_time), .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  change_logger #(.DATA_W(DATA_W), .TS_W(4), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .sample_in(s4),
    .out_valid(valid4), .out_ready(rdy4), .out_value(value4),
    .out_time(time4), .count(count4), .overflow(ovf4), .clear_ovf(clr4)
  );

  // Reference model: the log as a queue of entries plus the monitor's state.
  typedef struct {int unsigned t; int unsigned v;} ent_t;
  ent_t        m_q[$];
  int unsigned m_time  = 0;
  int unsigned m_prev  = 0;
  bit          m_armed = 1'b0;
  bit          m_ovf   = 1'b0;

  function automatic void step_model();
    bit pop, logit, drop;
    int sz;
    if (rst) begin
      m_q.delete();
      m_time = 0; m_prev = 0; m_armed = 0; m_ovf = 0;
      return;
    end
    sz    = m_q.size();
    pop   = (sz > 0) && out_ready;
    logit = enable && (!m_armed || (int'(sample_in) != m_prev));
    drop  = 0;
    if (pop) void'(m_q.pop_front());
    if (logit) begin
      if (sz < int'(DEPTH) || pop) m_q.push_back('{t: m_time, v: int'(sample_in)});
      else drop = 1;
      m_prev  = int'(sample_in);
      m_armed = 1;
    end
    if (!enable) m_armed = 0;
    if (drop) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    if (enable) m_time = (m_time + 1) % (1 << TS_W);
  endfunction

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] tog(input int i);
    return (i % 2 == 1) ? 4'h5 : 4'hA;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 ||
        out_value !== 4'd0 || out_time !== 16'd0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b value=%h time=%0d, want 0/0/0/0/0",
               out_valid, count, overflow, out_value, out_time);
    end
  endtask

  task automatic test_baseline();
    do_reset();
    enable = 1'b1; sample_in = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || count !== 4'd1 || out_time !== 16'd0 || out_value !== 4'b1010) begin
        errors++;
        $display("FAIL baseline cyc%0d: valid=%b count=%0d head={%0d,%b}, want 1/1/{0,1010}",
                 k, out_valid, count, out_time, out_value);
      end
    end
  endtask

  task automatic test_change_times();
    ent_t got[$];
    int unsigned exp_t[3] = '{0, 50, 150};
    logic [3:0]  exp_v[3] = '{4'b1010, 4'b1100, 4'b0000};
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 160; k++) begin
      sample_in = (k < 50) ? 4'b1010 : (k < 150) ? 4'b1100 : 4'b0000;
      tick();
      if (out_valid === 1'b1) got.push_back('{t: int'(out_time), v: int'(out_value)});
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL change_count: got %0d entries, want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i].t != exp_t[i] || got[i].v != int'(exp_v[i])) begin
        errors++;
        $display("FAIL change_entry%0d: {%0d,%0h}, want {%0d,%0h}", i, got[i].t, got[i].v, exp_t[i], exp_v[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL change_ovf: overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_in = tog(i);
      tick();
    end
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: count=%0d ovf=%b, want 8/1", count, overflow);
    end
    enable = 1'b0; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b count=%0d, want 0/8", overflow, count);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_time !== 16'(j) || out_value !== tog(j)) begin
        errors++;
        $display("FAIL ovf_drain%0d: valid=%b {%0d,%h}, want 1 {%0d,%h}", j, out_valid, out_time, out_value, j, tog(j));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL ovf_empty: valid=%b count=%0d, want 0/0", out_valid, count);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_in = tog(i);
      tick();
    end
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: count=%0d ovf=%b, want 8/0", count, overflow);
    end
    sample_in = tog(8); out_ready = 1'b1;
    tick();
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || out_time !== 16'd1) begin
      errors++;
      $display("FAIL full_pop: count=%0d ovf=%b head_t=%0d, want 8/0/1", count, overflow, out_time);
    end
    // Drop and clear on the same edge: the drop must win.
    sample_in = tog(9); out_ready = 1'b0; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL drop_vs_clear: ovf=%b count=%0d, want 1/8", overflow, count);
    end
  endtask

  task automatic test_wrap();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0; en4 = 1'b1; s4 = 4'h3; rdy4 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 17) s4 = 4'h9;
      tick();
    end
    checks++;
    if (count4 !== 4'd2 || time4 !== 4'd0 || value4 !== 4'h3) begin
      errors++;
      $display("FAIL wrap_first: count=%0d head={%0d,%h}, want 2 {0,3}", count4, time4, value4);
    end
    en4 = 1'b0; rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    checks++;
    if (valid4 !== 1'b1 || time4 !== 4'd1 || value4 !== 4'h9) begin
      errors++;
      $display("FAIL wrap_ts: valid=%b head={%0d,%h}, want 1 {1,9}", valid4, time4, value4);
    end
    rst4 = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_in = tog(i);
      tick();
    end
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL midrst_fill: count=%0d, want 3", count);
    end
    rst = 1'b1; sample_in = 4'hF; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b count=%0d ovf=%b, want 0/0/0", out_valid, count, overflow);
    end
    sample_in = 4'h7;
    tick();
    checks++;
    if (count !== 4'd1 || out_time !== 16'd0 || out_value !== 4'h7) begin
      errors++;
      $display("FAIL midrst_relog: count=%0d head={%0d,%h}, want 1 {0,7}", count, out_time, out_value);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    int rdy_pct = 50;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) rdy_pct = int'($urandom_range(10, 90));
      enable    = ($urandom_range(0, 9) != 0);
      sample_in = DATA_W'($urandom_range(0, 3));
      out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      clear_ovf = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (count !== 4'(m_q.size()) || out_valid !== (m_q.size() > 0) || overflow !== m_ovf ||
          (m_q.size() > 0 && (out_time !== 16'(m_q[0].t) || out_value !== DATA_W'(m_q[0].v)))) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc%0d: count=%0d valid=%b ovf=%b head={%0d,%h}, want count=%0d ovf=%b head={%0d,%h}",
                   c, count, out_valid, overflow, out_time, out_value, m_q.size(), m_ovf,
                   (m_q.size() > 0) ? m_q[0].t : 0, (m_q.size() > 0) ? m_q[0].v : 0);
        end
      end
    end
    rst = 1'b0; clear_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_change_times();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_logger.md
# change_logger

Synthesizable capture-side counterpart to our stimulus benches: watches a DATA_W-bit bus every clock and records each value change as a {timestamp, value} entry. It does in hardware what `$monitor` does in simulation. Entries are buffered in a small FIFO and drained by a consumer over a valid/ready interface. It sits on the output of a device under test, for example the B output of `simple`, so that waveforms can be checked on silicon or in long runs without VCD dumps.

## Interface
- DATA_W, 4, width of the monitored bus
- TS_W, 16, timestamp counter width
- DEPTH, 8, FIFO entries (power of two, at least 2)

- clk  in  1  sole clock; everything is updated on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture and timestamp counting enabled
- sample_in  in  DATA_W  monitored bus, sampled every clk edge
- out_valid  out  1  FIFO head entry available
- out_ready  in  1  consumer accepts the head entry
- out_value  out  DATA_W  head entry value
- out_time  out  TS_W  head entry timestamp
- count  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky flag: at least one entry was dropped
- clear_ovf  in  1  clears overflow

## Operation
- time_q: reset value 0. Increments by 1 on every edge with enable=1. Holds when enable=0. Wraps from 2^TS_W-1 to 0 silently.
- prev_q holds the last logged value. armed_q marks that a baseline exists.
- Log condition at an edge: enable=1 and (armed_q=0 or sample_in≠prev_q).
  - The first enabled edge always logs, like `$monitor`'s initial print.
- On a log:
  - push {time_q (pre-increment value), sample_in}
  - prev_q <= sample_in
  - armed_q <= 1
- enable=0 clears armed_q. Re-enabling therefore logs a fresh baseline.
- Pop occurs when out_valid and out_ready are both 1. The head advances.
- FIFO full and log condition true:
  - If a pop occurs on the same edge, the push is accepted and count is unchanged.
  - Otherwise the new entry is dropped and overflow <= 1. prev_q still updates, so a stuck-full FIFO does not re-log the same value.
- Empty FIFO: out_valid=0. out_value and out_time are don't-care but must be stable (no X) after reset.
- overflow is sticky. clear_ovf=1 clears it. If a drop and clear_ovf occur on the same edge, the drop wins and overflow stays 1.
- rst=1 at any edge, including mid-drain:
  - FIFO emptied, count=0
  - time_q=0, prev_q=0, armed_q=0, overflow=0
  - rst has priority over all other inputs.
- Reset values of outputs: out_valid=0, count=0, overflow=0, out_value=0, out_time=0.

## Timing
- Latency from log to visibility: 1 cycle. An entry logged at edge k is visible on out_valid/out_value/out_time after edge k, provided the FIFO was empty.
- First-word-fall-through: head outputs are registered FIFO contents, with no combinational path from out_ready to out_valid.
- Throughput: one push and one pop per cycle.
- count reflects pushes and pops of edge k immediately after edge k.
- sample_in is assumed synchronous to clk. No internal synchronizer.

## Structure
- Package change_logger_pkg holds:
  - default DATA_W, TS_W, DEPTH
  - ENTRY_W = TS_W + DATA_W
  - entry field offsets: value in [DATA_W-1:0], timestamp above it
- Sub-module sync_fifo (ENTRY_W wide, DEPTH deep, FWFT, full/empty/count). It is reusable by other capture blocks.
- Top level contains the timestamp counter, change detector, overflow logic and FIFO instance.

## Test plan
- Reset, then enable=1 with sample_in=4'b1010 held. Exactly one entry {time 0, 1010}. Then out_valid stays 1 with no further pushes. count=1.
- Drive 1010 → 1100 at cycle 50 → 0000 at cycle 150, out_ready=1. Entries read: {0,1010}, {50,1100}, {150,0000}. No overflow.
- out_ready=0, DEPTH=8, toggle sample_in every cycle for 12 cycles:
  - count saturates at 8, overflow=1, the first 8 entries are intact.
  - clear_ovf pulse → overflow=0.
- FIFO full with a change arriving together with out_ready=1 on the same edge. The push is accepted, count stays 8, overflow stays 0.
- TS_W=4, sample_in change at cycle 17. Entry timestamp = 1 (wrap).
- Mid-stream: rst for 1 cycle with 3 entries queued. out_valid=0 and count=0 after the edge. The next enabled edge logs {0, sample_in}.
